// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared fetch-pipeline definitions: NOP encoding, PC increment and the
// one-hot fetch state encodings used by the stall/flush controller.
package fetch_stall_ctrl_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [2:0] {
    RUN   = 3'b001,
    HOLD  = 3'b010,
    FLUSH = 3'b100
  } state_t;

endpackage

// File: rtl/fetch_stall_ctrl_stall_watchdog.sv
// Counts consecutive honoured stall cycles and forces a release once the
// limit is reached, latching a sticky error flag when it does so.
module stall_watchdog #(
  parameter int MAX_STALL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_req,
  input  logic clear,
  output logic wd_fire,
  output logic stall_err
);

  if (MAX_STALL < 1 || MAX_STALL > 15) begin : g_bad_max_stall
    $error("stall_watchdog: MAX_STALL must be in 1..15");
  end

  localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);

  logic [3:0] stall_cnt;

  assign wd_fire = stall_req & (stall_cnt == MAX_CNT);

  // A stall cycle is only counted when it is actually honoured as a hold;
  // a branch, a flush cycle, a forced release or a dropped request restart it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 4'd0;
      stall_err <= 1'b0;
    end else begin
      if (clear || wd_fire || !stall_req) begin
        stall_cnt <= 4'd0;
      end else if (stall_cnt != MAX_CNT) begin
        stall_cnt <= stall_cnt + 4'd1;
      end
      if (wd_fire && !clear) begin
        stall_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side stall/flush controller: owns the PC and IF/ID register and
// turns hazard-unit stall requests into holds and ID/EX bubbles.
module fetch_stall_ctrl
  import fetch_stall_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_STALL = 4,
  parameter logic [31:0] NOP_INST  = fetch_stall_ctrl_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_inst,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic        id_ex_bubble,
  output logic        stall_err
);

  if (MAX_STALL < 1 || MAX_STALL > 15) begin : g_bad_max_stall
    $error("fetch_stall_ctrl: MAX_STALL must be in 1..15");
  end

  state_t state;
  logic   wd_fire;
  logic   wd_clear;
  logic   eff_stall;

  // The NOP sitting in IF/ID during a flush can alias a load-use hazard on
  // r0, so stall requests are not honoured (nor counted) in that cycle.
  assign wd_clear     = branch_taken | (state == FLUSH);
  assign eff_stall    = stall & ~wd_clear & ~wd_fire;
  assign id_ex_bubble = eff_stall & ~rst;

  stall_watchdog #(
    .MAX_STALL(MAX_STALL)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .stall_req(stall),
    .clear    (wd_clear),
    .wd_fire  (wd_fire),
    .stall_err(stall_err)
  );

  // Priority: reset, branch redirect, honoured stall, normal advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_PC;
      IF_ID_inst <= NOP_INST;
      IF_ID_pc   <= 32'd0;
    end else if (branch_taken) begin
      state      <= FLUSH;
      pc         <= branch_target;
      IF_ID_inst <= NOP_INST;
      IF_ID_pc   <= 32'd0;
    end else if (eff_stall) begin
      state      <= HOLD;
    end else begin
      state      <= RUN;
      pc         <= pc + PC_INC;
      IF_ID_inst <= imem_inst;
      IF_ID_pc   <= pc;
    end
  end

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Self-checking bench for fetch_stall_ctrl: directed scenarios plus random
// traffic, compared every cycle against a behavioural pipeline model.
module tb_fetch_stall_ctrl;

  localparam int          MAX_STALL = 4;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_inst;
  logic [31:0] pc;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc;
  logic        id_ex_bubble;
  logic        stall_err;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_inst, m_ipc;
  logic        m_flush, m_err, m_bubble;
  int          m_holds;
  logic        last_bubble;

  always #5 clk = ~clk;

  fetch_stall_ctrl #(
    .RESET_PC (RESET_PC),
    .MAX_STALL(MAX_STALL),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_inst    (imem_inst),
    .pc           (pc),
    .IF_ID_inst   (IF_ID_inst),
    .IF_ID_pc     (IF_ID_pc),
    .id_ex_bubble (id_ex_bubble),
    .stall_err    (stall_err)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check32("pc", pc, m_pc);
    check32("IF_ID_inst", IF_ID_inst, m_inst);
    check32("IF_ID_pc", IF_ID_pc, m_ipc);
    check32("stall_err", {31'd0, stall_err}, {31'd0, m_err});
  endtask

  // One full clock cycle: drive inputs, check the combinational bubble,
  // clock the edge, advance the model, check registered outputs.
  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] tgt, input logic [31:0] inst);
    logic [31:0] n_pc, n_inst, n_ipc;
    logic        n_flush, n_err;
    int          n_holds;
    rst = r; stall = s; branch_taken = b; branch_target = tgt; imem_inst = inst;
    #1;
    n_pc = m_pc; n_inst = m_inst; n_ipc = m_ipc;
    n_flush = 1'b0; n_err = m_err; n_holds = 0; m_bubble = 1'b0;
    if (r) begin
      n_pc = RESET_PC; n_inst = 32'd0; n_ipc = 32'd0; n_err = 1'b0;
    end else if (b) begin
      n_pc = tgt; n_inst = 32'd0; n_ipc = 32'd0; n_flush = 1'b1;
    end else if (s && !m_flush && m_holds < MAX_STALL) begin
      m_bubble = 1'b1;
      n_holds  = m_holds + 1;
    end else begin
      if (s && !m_flush) n_err = 1'b1;
      n_inst = inst; n_ipc = m_pc; n_pc = m_pc + 32'd4;
    end
    check32("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, m_bubble});
    last_bubble = id_ex_bubble;
    @(posedge clk);
    #1;
    m_pc = n_pc; m_inst = n_inst; m_ipc = n_ipc;
    m_flush = n_flush; m_err = n_err; m_holds = n_holds;
    checkOutput();
  endtask

  initial begin
    int bubbles;
    logic [31:0] rnd, tgt;
    m_pc = 32'd0; m_inst = 32'd0; m_ipc = 32'd0;
    m_flush = 1'b0; m_err = 1'b0; m_holds = 0; m_bubble = 1'b0;

    // Reset
    applyStimulus(1, 0, 0, 32'd0, 32'hDEAD_BEEF);
    applyStimulus(1, 1, 0, 32'd0, 32'hDEAD_BEEF);
    check32("lit reset pc", pc, 32'h0);
    check32("lit reset inst", IF_ID_inst, 32'h0);
    check32("lit reset err", {31'd0, stall_err}, 32'd0);

    // Free run A,B then a single stall at pc=8, then C
    applyStimulus(0, 0, 0, 32'd0, 32'hAAAA_0001);
    check32("lit pc4", pc, 32'h4);
    applyStimulus(0, 0, 0, 32'd0, 32'hBBBB_0002);
    check32("lit pc8", pc, 32'h8);
    applyStimulus(0, 1, 0, 32'd0, 32'hCCCC_0003);
    check32("lit stall bubble", {31'd0, last_bubble}, 32'd1);
    check32("lit hold pc", pc, 32'h8);
    check32("lit hold inst", IF_ID_inst, 32'hBBBB_0002);
    check32("lit hold ipc", IF_ID_pc, 32'h4);
    applyStimulus(0, 0, 0, 32'd0, 32'hCCCC_0003);
    check32("lit pc12", pc, 32'hC);
    check32("lit inst C", IF_ID_inst, 32'hCCCC_0003);
    check32("lit ipc 8", IF_ID_pc, 32'h8);

    // Branch with stall: branch wins, then stall in FLUSH ignored
    applyStimulus(0, 1, 1, 32'h100, 32'h1234_5678);
    check32("lit br bubble", {31'd0, last_bubble}, 32'd0);
    check32("lit br pc", pc, 32'h100);
    check32("lit br inst", IF_ID_inst, 32'h0);
    applyStimulus(0, 1, 0, 32'd0, 32'hD000_0100);
    check32("lit flush bubble", {31'd0, last_bubble}, 32'd0);
    check32("lit flush pc", pc, 32'h104);
    check32("lit flush ipc", IF_ID_pc, 32'h100);

    // Stuck stall: 4 holds, forced release, repeat
    bubbles = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 32'd0, 32'hE000_0000 + 32'(i));
      if (last_bubble) bubbles++;
      if (i == 4) check32("lit wd release bubble", {31'd0, last_bubble}, 32'd0);
    end
    check32("lit wd bubble count", 32'(bubbles), 32'd8);
    check32("lit wd err", {31'd0, stall_err}, 32'd1);
    applyStimulus(0, 0, 0, 32'd0, 32'h0F0F_0F0F);
    check32("lit err sticky", {31'd0, stall_err}, 32'd1);

    // Reset in the middle of a hold
    applyStimulus(0, 1, 0, 32'd0, 32'h1);
    applyStimulus(0, 1, 0, 32'd0, 32'h2);
    applyStimulus(1, 1, 0, 32'd0, 32'h3);
    check32("lit midhold rst pc", pc, RESET_PC);
    check32("lit midhold rst err", {31'd0, stall_err}, 32'd0);

    // PC wrap
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 32'h5);
    applyStimulus(0, 0, 0, 32'd0, 32'h6666_6666);
    check32("lit wrap pc", pc, 32'h0);
    check32("lit wrap ipc", IF_ID_pc, 32'hFFFF_FFFC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rnd = $urandom;
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      if (rnd[15:12] == 4'hF) tgt = 32'hFFFF_FFF8;
      applyStimulus(rnd[7:0] < 8'd4, rnd[8] | rnd[9] | (rnd[16] & rnd[17]),
                    rnd[11:10] == 2'b11 && rnd[20], tgt, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
